// File: rtl/uart_tx_arbiter_if.sv
// Byte-request / UART TX handshake bundle for uart_tx_arbiter.
// master: the arbiter side. slave: the producers plus the TX as seen from outside.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         P_DATA;
  logic                          Data_Valid;
  logic                          Busy;
  logic [OwnerW-1:0]             owner;
  logic                          arb_busy;
  logic                          tx_err;

  modport master (
    input  req, req_data, Busy,
    output grant, P_DATA, Data_Valid, owner, arb_busy, tx_err
  );

  modport slave (
    output req, req_data, Busy,
    input  grant, P_DATA, Data_Valid, owner, arb_busy, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters.
// Round-robin by default; defining UART_ARB_FIXED_PRI_EN selects fixed priority
// (lowest set req index wins). All outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned OwnerW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned ToW     = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToLast  = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e                  state_q, state_d;
  logic [OwnerW-1:0]       ptr_q, ptr_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    dv_q, dv_d;
  logic                    tx_err_q, tx_err_d;
  logic                    arb_busy_q, arb_busy_d;
  logic [ToW-1:0]          to_cnt_q, to_cnt_d;
  logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;

  logic                    win_found;
  logic [OwnerW-1:0]       win_idx;
  logic [OwnerW-1:0]       scan_idx;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Winner search: first set req bit scanning upward (with wrap) from the start index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef UART_ARB_FIXED_PRI_EN
      scan_idx = OwnerW'(i);
`else
      scan_idx = OwnerW'((32'(ptr_q) + i) % NUM_REQ);
`endif
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = '0;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    tx_err_d  = 1'b0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d  = NUM_REQ'(1) << win_idx;
          p_data_d = data_arr[win_idx];
          owner_d  = win_idx;
          ptr_d    = (win_idx == OwnerW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        dv_d     = 1'b1;
        to_cnt_d = '0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.Busy) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == ToW'(ToLast)) begin
          // TX never acknowledged; the byte is dropped, not retried.
          tx_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.Busy) begin
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            gap_cnt_d = GapW'(GapLoad);
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    arb_busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      tx_err_q   <= 1'b0;
      arb_busy_q <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      tx_err_q   <= tx_err_d;
      arb_busy_q <= arb_busy_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.owner      = owner_q;
  assign bus.arb_busy   = arb_busy_q;
  assign bus.tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by randomized
// request traffic, checked against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned Gap  = 2;
  localparam int unsigned Tout = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NReq), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NReq),
    .DATA_WIDTH  (DW),
    .GAP_CYCLES  (Gap),
    .BUSY_TIMEOUT(Tout)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [NReq-1:0] pending;
  logic [DW-1:0]   data_m [NReq];
  int              ptr_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: first pending index scanning upward from the pointer, with wrap.
  function automatic int pick(input logic [NReq-1:0] r, input int p);
    int base;
    base = p;
`ifdef UART_ARB_FIXED_PRI_EN
    base = 0;
`endif
    for (int i = 0; i < NReq; i++) begin
      int idx;
      idx = (base + i) % NReq;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic add_one(input int i, input logic [DW-1:0] d);
    if (!pending[i]) begin
      data_m[i] = d;
      bus.req_data[i*DW +: DW] = d;
      pending[i] = 1'b1;
    end
    bus.req = pending;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_dv"}, 32'(bus.Data_Valid), 0);
    chk({tag, "_pdata"}, 32'(bus.P_DATA), 0);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
    chk({tag, "_arb_busy"}, 32'(bus.arb_busy), 0);
    chk({tag, "_tx_err"}, 32'(bus.tx_err), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Busy = 1'b0;
    pending = '0;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // One full transaction; entered in a cycle where the arbiter is idle and req is driven.
  task automatic run_frame(input int w, input int blen, input bit tout,
                           input logic [NReq-1:0] mid_add, input bit mid_drop);
    logic [DW-1:0] exp_b;
    exp_b = data_m[w];
    tick();
    chk("grant", 32'(bus.grant), 32'(1) << w);
    chk("owner", 32'(bus.owner), 32'(w));
    chk("arb_busy_at_grant", 32'(bus.arb_busy), 1);
    chk("dv_at_grant", 32'(bus.Data_Valid), 0);
    chk("tx_err_low", 32'(bus.tx_err), 0);
    pending[w] = 1'b0;
    bus.req = pending;
    bus.req_data[w*DW +: DW] = DW'($urandom);
    ptr_m = (w + 1) % NReq;
    tick();
    chk("grant_one_cycle", 32'(bus.grant), 0);
    chk("dv_pulse", 32'(bus.Data_Valid), 1);
    chk("p_data", 32'(bus.P_DATA), 32'(exp_b));
    for (int i = 0; i < NReq; i++) if (mid_add[i]) add_one(i, DW'($urandom));
    if (mid_drop) begin
      for (int i = 0; i < NReq; i++) begin
        if (pending[i]) begin
          pending[i] = 1'b0;
          break;
        end
      end
      bus.req = pending;
    end
    if (tout) begin
      for (int k = 1; k < Tout; k++) begin
        tick();
        chk("tout_no_err", 32'(bus.tx_err), 0);
        chk("tout_dv_low", 32'(bus.Data_Valid), 0);
        chk("tout_arb_busy", 32'(bus.arb_busy), 1);
        chk("tout_grant_low", 32'(bus.grant), 0);
      end
      tick();
      chk("tout_err", 32'(bus.tx_err), 1);
      chk("tout_idle", 32'(bus.arb_busy), 0);
      chk("tout_pdata_hold", 32'(bus.P_DATA), 32'(exp_b));
    end else begin
      tick();
      chk("dv_single", 32'(bus.Data_Valid), 0);
      tick();
      bus.Busy = 1'b1;
      for (int k = 0; k < blen; k++) begin
        tick();
        chk("frame_arb_busy", 32'(bus.arb_busy), 1);
        chk("frame_grant_low", 32'(bus.grant), 0);
      end
      bus.Busy = 1'b0;
      for (int g = 0; g < Gap; g++) begin
        tick();
        chk("gap_arb_busy", 32'(bus.arb_busy), 1);
        chk("gap_grant_low", 32'(bus.grant), 0);
      end
      tick();
      chk("back_idle", 32'(bus.arb_busy), 0);
      chk("no_tx_err", 32'(bus.tx_err), 0);
      chk("pdata_hold", 32'(bus.P_DATA), 32'(exp_b));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.req = '0;
    bus.req_data = '0;
    bus.Busy = 1'b0;
    pending = '0;
    ptr_m = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("idle_no_grant", 32'(bus.grant), 0);
      chk("idle_not_busy", 32'(bus.arb_busy), 0);
    end

    // Single request, long TX frame.
    add_one(0, 8'hA5);
    run_frame(0, 10, 1'b0, '0, 1'b0);

    // All four requesters at once after reset; requester 0 comes back later.
    do_reset();
    add_one(0, 8'h11);
    add_one(1, 8'h22);
    add_one(2, 8'h33);
    add_one(3, 8'h44);
    run_frame(0, 3, 1'b0, '0, 1'b0);
    run_frame(1, 3, 1'b0, '0, 1'b0);
    run_frame(2, 3, 1'b0, '0, 1'b0);
    run_frame(3, 3, 1'b0, 4'b0001, 1'b0);
    run_frame(0, 3, 1'b0, '0, 1'b0);

    // Busy never rises: timeout, then a normal grant.
    add_one(2, 8'h5C);
    run_frame(2, 0, 1'b1, '0, 1'b0);
    add_one(1, 8'h3E);
    run_frame(1, 4, 1'b0, '0, 1'b0);

    // Requests 3 and 1 raised while requester 2 is being served.
    add_one(2, 8'h77);
    run_frame(2, 3, 1'b0, 4'b1010, 1'b0);
`ifdef UART_ARB_FIXED_PRI_EN
    run_frame(1, 2, 1'b0, '0, 1'b0);
    run_frame(3, 2, 1'b0, '0, 1'b0);
`else
    run_frame(3, 2, 1'b0, '0, 1'b0);
    run_frame(1, 2, 1'b0, '0, 1'b0);
`endif

    // Reset while the TX frame is in progress.
    add_one(3, 8'h9A);
    tick();
    chk("rst_pre_grant", 32'(bus.grant), 32'h8);
    pending = '0;
    bus.req = '0;
    tick();
    tick();
    tick();
    bus.Busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    bus.Busy = 1'b0;
    ptr_m = 0;
    add_one(1, 8'hC3);
    add_one(3, 8'h3C);
    run_frame(1, 2, 1'b0, '0, 1'b0);
    run_frame(3, 2, 1'b0, '0, 1'b0);

    // A request raised and withdrawn while held off produces nothing.
    add_one(0, 8'h01);
    run_frame(0, 2, 1'b0, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dropped_no_grant", 32'(bus.grant), 0);
      chk("dropped_no_dv", 32'(bus.Data_Valid), 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [NReq-1:0] nb;
      if (pending == '0) begin
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int k = 0; k < idle; k++) begin
          tick();
          chk("rand_idle_grant", 32'(bus.grant), 0);
          chk("rand_idle_busy", 32'(bus.arb_busy), 0);
        end
        nb = NReq'($urandom_range(1, 15));
      end else begin
        nb = ($urandom_range(0, 1) == 0) ? '0 : NReq'($urandom);
      end
      for (int i = 0; i < NReq; i++) if (nb[i]) add_one(i, DW'($urandom));
      w = pick(pending, ptr_m);
      run_frame(w, int'($urandom_range(1, 10)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) == 0) ? NReq'($urandom) : '0,
                ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
